// File: rtl/inv_cipher_core.sv
// Iterative AES-128 inverse cipher core: applies one InvCipher round per clock as commanded by the controller.
// Optional build macro INV_CIPHER_SEQ_CHECK_EN adds round-order checking with a sticky seq_err_out.
module inv_cipher_core #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            FSM_core_in,
  input  logic [3:0]            core_count_in,
  input  logic [DATA_WIDTH-1:0] text_0_in,
  input  logic [DATA_WIDTH-1:0] text_1_in,
  input  logic [DATA_WIDTH-1:0] text_2_in,
  input  logic [DATA_WIDTH-1:0] text_3_in,
  input  logic [DATA_WIDTH-1:0] key_0_in,
  input  logic [DATA_WIDTH-1:0] key_1_in,
  input  logic [DATA_WIDTH-1:0] key_2_in,
  input  logic [DATA_WIDTH-1:0] key_3_in,
  output logic [DATA_WIDTH-1:0] text_0_out,
  output logic [DATA_WIDTH-1:0] text_1_out,
  output logic [DATA_WIDTH-1:0] text_2_out,
  output logic [DATA_WIDTH-1:0] text_3_out,
`ifdef INV_CIPHER_SEQ_CHECK_EN
  output logic                  seq_err_out,
`endif
  output logic                  cipher_dv_flag
);

  localparam int unsigned STATE_W = 4 * DATA_WIDTH;

  localparam logic [2:0] CMD_IDLE  = 3'b000;
  localparam logic [2:0] CMD_LOAD  = 3'b001;
  localparam logic [2:0] CMD_ROUND = 3'b010;
  localparam logic [2:0] CMD_HOLD  = 3'b011;

  // Inverse S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return res;
  endfunction

  // Column multiply by {0e,0b,0d,09} circulant built from xtime chains.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [3:0][7:0] a, m9, mb, md, me;
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
            inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
  endfunction

  logic [STATE_W-1:0] state_q, state_d;
  logic               dv_q, dv_d;
  logic [STATE_W-1:0] text_in, key_in, round_out;
`ifdef INV_CIPHER_SEQ_CHECK_EN
  logic [3:0]         exp_cnt_q, exp_cnt_d;
  logic               seq_err_q, seq_err_d;
`endif

  assign text_in   = {text_0_in, text_1_in, text_2_in, text_3_in};
  assign key_in    = {key_0_in, key_1_in, key_2_in, key_3_in};
  assign round_out = inv_sub_bytes(inv_shift_rows(state_q)) ^ key_in;

  // Next-state decode of the controller command.
  always_comb begin
    state_d = state_q;
    dv_d    = dv_q;
`ifdef INV_CIPHER_SEQ_CHECK_EN
    exp_cnt_d = exp_cnt_q;
    seq_err_d = seq_err_q;
`endif
    case (FSM_core_in)
      CMD_LOAD: begin
        state_d = text_in;
        dv_d    = 1'b0;
`ifdef INV_CIPHER_SEQ_CHECK_EN
        exp_cnt_d = 4'd0;
        seq_err_d = 1'b0;
`endif
      end
      CMD_ROUND: begin
`ifdef INV_CIPHER_SEQ_CHECK_EN
        exp_cnt_d = exp_cnt_q + 4'd1;
        if (core_count_in != exp_cnt_q) seq_err_d = 1'b1;
`endif
        if (core_count_in == 4'd0) begin
          state_d = state_q ^ key_in;
        end else if (core_count_in <= 4'd9) begin
          state_d = inv_mix_columns(round_out);
        end else if (core_count_in == 4'd10) begin
          state_d = round_out;
`ifdef INV_CIPHER_SEQ_CHECK_EN
          if (!seq_err_d) dv_d = 1'b1;
`else
          dv_d = 1'b1;
`endif
        end
      end
      CMD_HOLD: ;
      default: dv_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      dv_q    <= 1'b0;
`ifdef INV_CIPHER_SEQ_CHECK_EN
      exp_cnt_q <= 4'd0;
      seq_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dv_q    <= dv_d;
`ifdef INV_CIPHER_SEQ_CHECK_EN
      exp_cnt_q <= exp_cnt_d;
      seq_err_q <= seq_err_d;
`endif
    end
  end

  assign {text_0_out, text_1_out, text_2_out, text_3_out} = state_q;
  assign cipher_dv_flag = dv_q;
`ifdef INV_CIPHER_SEQ_CHECK_EN
  assign seq_err_out = seq_err_q;
`endif

endmodule
